// File: rtl/io_mem_responder.sv
// Burst read/write responder over a single-port synchronous RAM, one burst in flight at a time.
// First read beat 2 cycles after the address handshake; a 2-entry read buffer absorbs rdata_ready stalls.
module io_mem_responder #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int LOGDEPTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] req_read_addr,
    input  logic              req_read_addr_valid,
    output logic              req_read_addr_ready,
    input  logic [31:0]       req_read_len,
    output logic [DWIDTH-1:0] rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    input  logic [AWIDTH-1:0] req_write_addr,
    input  logic              req_write_addr_valid,
    output logic              req_write_addr_ready,
    input  logic [31:0]       req_write_len,
    input  logic [DWIDTH-1:0] req_write_data,
    input  logic              req_write_data_valid,
    output logic              req_write_data_ready,
    output logic              resp_write_status,
    output logic              resp_write_status_valid,
    input  logic              resp_write_status_ready
);
    localparam int IW = AWIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WRESP} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [31:0]           r_len;
    logic [31:0]           r_issue_cnt;
    logic [31:0]           r_beat_cnt;
    logic                  r_ok;
    logic                  r_pend;
    logic                  r_pend_oor;
    logic [DWIDTH-1:0]     r_buf [2];
    logic                  r_head;
    logic [1:0]            r_cnt;
    logic [DWIDTH-1:0]     r_mem_q;
    logic [DWIDTH-1:0]     r_mem [0:(1<<LOGDEPTH)-1];

    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_beat_fire;
    logic                  w_wd_fire;
    logic                  w_cur_oor;
    logic [1:0]            w_occ;
    logic                  w_rd_start;
    logic                  w_rd_issue;
    logic                  w_issue_oor;
    logic [LOGDEPTH-1:0]   w_mem_addr;
    logic                  w_mem_we;
    logic                  w_slot;
    logic                  w_unused;

    assign req_write_addr_ready    = ~rst & (r_state == S_IDLE);
    assign req_read_addr_ready     = ~rst & (r_state == S_IDLE) & ~req_write_addr_valid;
    assign req_write_data_ready    = ~rst & (r_state == S_WRITE);
    assign rdata_valid             = ~rst & (r_cnt != 2'd0);
    assign rdata                   = rdata_valid ? r_buf[r_head] : '0;
    assign resp_write_status_valid = ~rst & (r_state == S_WRESP);
    assign resp_write_status       = ~rst & (r_state == S_WRESP) & r_ok;

    assign w_rd_fire   = req_read_addr_valid & req_read_addr_ready;
    assign w_wr_fire   = req_write_addr_valid & req_write_addr_ready;
    assign w_beat_fire = rdata_valid & rdata_ready;
    assign w_wd_fire   = req_write_data_valid & req_write_data_ready;
    assign w_cur_oor   = |r_idx[IW-1:LOGDEPTH];
    assign w_unused    = ^{req_read_addr[1:0], req_write_addr[1:0]};

    // Buffer occupancy after this edge; a new RAM read may issue only if its data will still fit.
    assign w_occ       = r_cnt + {1'b0, r_pend} - {1'b0, w_beat_fire};
    assign w_rd_start  = w_rd_fire & (req_read_len != 32'd0);
    assign w_rd_issue  = w_rd_start |
                         ((r_state == S_READ) & (r_issue_cnt != r_len) & (w_occ <= 2'd1));
    assign w_issue_oor = (r_state == S_IDLE) ? |req_read_addr[AWIDTH-1:LOGDEPTH+2] : w_cur_oor;
    assign w_mem_addr  = (r_state == S_IDLE) ? req_read_addr[LOGDEPTH+1:2] : r_idx[LOGDEPTH-1:0];
    assign w_mem_we    = (r_state == S_WRITE) & w_wd_fire & ~w_cur_oor;
    assign w_slot      = r_head ^ r_cnt[0];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= req_write_data;
        end
        r_mem_q <= r_mem[w_mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_ok        <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_oor  <= 1'b0;
            r_head      <= 1'b0;
            r_cnt       <= 2'd0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
        end else begin
            r_pend     <= w_rd_issue;
            r_pend_oor <= w_issue_oor;
            if (r_pend) begin
                r_buf[w_slot] <= r_pend_oor ? '0 : r_mem_q;
            end
            r_cnt  <= w_occ;
            r_head <= r_head ^ w_beat_fire;

            case (r_state)
                S_IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_wr_fire) begin
                        r_idx   <= req_write_addr[AWIDTH-1:2];
                        r_len   <= req_write_len;
                        r_ok    <= 1'b1;
                        r_state <= (req_write_len == 32'd0) ? S_WRESP : S_WRITE;
                    end else if (w_rd_fire) begin
                        r_idx       <= req_read_addr[AWIDTH-1:2] + IW'(1);
                        r_len       <= req_read_len;
                        r_issue_cnt <= {31'd0, w_rd_start};
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        r_idx       <= r_idx + IW'(1);
                        r_issue_cnt <= r_issue_cnt + 32'd1;
                    end
                    if (r_len == 32'd0) begin
                        r_state <= S_IDLE;
                    end else if (w_beat_fire) begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        if (r_beat_cnt + 32'd1 == r_len) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_wd_fire) begin
                        if (w_cur_oor) begin
                            r_ok <= 1'b0;
                        end
                        r_idx      <= r_idx + IW'(1);
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        if (r_beat_cnt + 32'd1 == r_len) begin
                            r_state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (resp_write_status_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_mem_responder.sv
// Directed bench for io_mem_responder: scoreboard of expected read beats checked as they fire.
module tb_io_mem_responder;
    localparam int AWIDTH   = 32;
    localparam int DWIDTH   = 32;
    localparam int LOGDEPTH = 12;
    localparam int DEPTH    = 1 << LOGDEPTH;

    logic              clk;
    logic              rst;
    logic [AWIDTH-1:0] req_read_addr;
    logic              req_read_addr_valid;
    logic              req_read_addr_ready;
    logic [31:0]       req_read_len;
    logic [DWIDTH-1:0] rdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [AWIDTH-1:0] req_write_addr;
    logic              req_write_addr_valid;
    logic              req_write_addr_ready;
    logic [31:0]       req_write_len;
    logic [DWIDTH-1:0] req_write_data;
    logic              req_write_data_valid;
    logic              req_write_data_ready;
    logic              resp_write_status;
    logic              resp_write_status_valid;
    logic              resp_write_status_ready;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] wbuf [16];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    io_mem_responder #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .LOGDEPTH(LOGDEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
        .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .req_write_addr(req_write_addr), .req_write_addr_valid(req_write_addr_valid),
        .req_write_addr_ready(req_write_addr_ready), .req_write_len(req_write_len),
        .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
        .req_write_data_ready(req_write_data_ready), .resp_write_status(resp_write_status),
        .resp_write_status_valid(resp_write_status_valid),
        .resp_write_status_ready(resp_write_status_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {req_write_addr_ready, req_read_addr_ready, req_write_data_ready, rdata_valid,
                resp_write_status_valid, resp_write_status, |rdata};
    endfunction

    function automatic logic rdy_pat(input int c, input bit toggle);
        if (!toggle) return 1'b1;
        return (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
    endfunction

    // Read beat monitor: pops the scoreboard on each fire and checks hold-stability during stalls.
    always @(negedge clk) begin
        if (prev_stall && !rst) begin
            check("rd_hold_valid", rdata_valid, 1);
            check("rd_hold_data", rdata, prev_data);
        end
        prev_stall = rdata_valid && !rdata_ready;
        prev_data  = rdata;
        if (rdata_valid && rdata_ready) begin
            check("rd_beat_expected", sb.size() != 0, 1);
            if (sb.size() != 0) check("rd_data", rdata, sb.pop_front());
        end
    end

    task automatic idle_chk();
        @(negedge clk);
        check("idle_wr_ready", req_write_addr_ready, 1);
        check("idle_resp_valid", resp_write_status_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int hold, input logic exp_st);
        bit got = 0;
        int unsigned idx;
        req_write_addr = addr; req_write_len = len; req_write_addr_valid = 1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_read_addr_valid) check("wr_beats_rd", req_read_addr_ready, 0);
            if (req_write_addr_ready) got = 1;
            @(posedge clk); #1;
        end
        req_write_addr_valid = 0;
        check("wr_req_accepted", got, 1);
        if (!got) return;
        for (int i = 0; i < len; i++) begin
            req_write_data = wbuf[i]; req_write_data_valid = 1;
            @(negedge clk);
            check("wr_data_ready", req_write_data_ready, 1);
            if (req_read_addr_valid) check("wr_rd_blocked", req_read_addr_ready, 0);
            @(posedge clk); #1;
            idx = (addr >> 2) + i;
            if (idx < DEPTH) model[idx] = wbuf[i];
        end
        req_write_data_valid = 0; req_write_data = '0;
        for (int h = 0; h <= hold; h++) begin
            resp_write_status_ready = (h == hold);
            @(negedge clk);
            check("wr_resp_valid", resp_write_status_valid, 1);
            check("wr_resp_status", resp_write_status, exp_st);
            check("wr_resp_no_accept",
                  {req_write_addr_ready, req_read_addr_ready, req_write_data_ready}, 0);
            @(posedge clk); #1;
        end
        resp_write_status_ready = 0;
    endtask

    task automatic rd_req(input logic [31:0] addr, input int len, input bit imm);
        bit got = 0;
        int first = -1;
        int unsigned idx;
        for (int i = 0; i < len; i++) begin
            idx = (addr >> 2) + i;
            sb.push_back(idx < DEPTH ? model[idx] : 32'd0);
        end
        req_read_addr = addr; req_read_len = len; req_read_addr_valid = 1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_read_addr_ready) begin got = 1; first = i; end
            @(posedge clk); #1;
        end
        req_read_addr_valid = 0;
        check("rd_req_accepted", got, 1);
        if (imm) check("rd_req_immediate", first, 0);
        if (!got) sb.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input bit toggle, input bit imm);
        bit done = 0;
        int last_c = 0;
        int exp_last = 0;
        int n = 0;
        rd_req(addr, len, imm);
        // Stalls delay beats one-for-one: beat k fires on the k-th ready cycle from T+2 on.
        for (int c = 2; c < 300 && n < len; c++) begin
            if (rdy_pat(c, toggle)) begin
                n++;
                if (n == len) exp_last = c;
            end
        end
        for (int c = 1; c <= 300 && !done; c++) begin
            rdata_ready = rdy_pat(c, toggle);
            @(negedge clk);
            if (c == 1) check("rd_first_early", rdata_valid, 0);
            if (c == 2) check("rd_first_beat", rdata_valid, 1);
            @(posedge clk); #1;
            if (sb.size() == 0) begin done = 1; last_c = c; end
        end
        check("rd_done", done, 1);
        check("rd_last_cycle", last_c, exp_last);
        rdata_ready = 0;
        @(negedge clk);
        check("rd_no_extra", rdata_valid, 0);
        check("rd_idle_ready", req_read_addr_ready, 1);
        @(posedge clk); #1;
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1;
        req_read_addr = '0; req_read_addr_valid = 0; req_read_len = '0; rdata_ready = 0;
        req_write_addr = '0; req_write_addr_valid = 0; req_write_len = '0;
        req_write_data = '0; req_write_data_valid = 0; resp_write_status_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outs", outs(), 7'b0000000);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("idle_outs", outs(), 7'b1100000);
        @(posedge clk); #1;

        // Write then read back.
        for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
        do_write(32'h40, 4, 0, 1'b1);
        idle_chk();
        do_read(32'h40, 4, 1'b0, 1'b0);

        // Read backpressure over a 9-beat burst.
        for (int i = 0; i < 9; i++) wbuf[i] = 10 + i;
        do_write(32'h80, 9, 0, 1'b1);
        idle_chk();
        do_read(32'h80, 9, 1'b1, 1'b0);

        // Simultaneous read and write requests: write first, read after response.
        req_read_addr = 32'h100; req_read_len = 2; req_read_addr_valid = 1;
        wbuf[0] = 32'h55; wbuf[1] = 32'h66;
        do_write(32'h100, 2, 2, 1'b1);
        do_read(32'h100, 2, 1'b0, 1'b1);

        // Zero-length write, then a burst straddling the top of memory.
        do_write(32'h300, 0, 0, 1'b1);
        idle_chk();
        wbuf[0] = 32'hA; wbuf[1] = 32'hB;
        do_write((DEPTH - 1) * 4, 2, 0, 1'b0);
        idle_chk();
        do_read((DEPTH - 1) * 4, 2, 1'b0, 1'b0);

        // Response held back for 5 cycles.
        wbuf[0] = 32'h77;
        do_write(32'h400, 1, 5, 1'b1);
        idle_chk();

        // Reset in the middle of a read burst; memory contents survive.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + i;
        do_write(32'h200, 8, 0, 1'b1);
        idle_chk();
        rd_req(32'h200, 8, 1'b0);
        rdata_ready = 1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_popped", sb.size(), 6);
        rst = 1;
        sb.delete();
        @(negedge clk);
        check("rst_mid_outs", outs(), 7'b0000000);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_outs_next", outs(), 7'b0000000);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_release_idle", outs(), 7'b1100000);
        repeat (4) begin @(posedge clk); #1; end
        rdata_ready = 0;
        do_read(32'h200, 8, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
